// File: rtl/pipe_scroller.sv
// Scrolling pipe obstacle generator: NUM_PIPES channels move left each frame,
// wrap to the right with an LFSR-chosen gap, count passed pipes and freeze on collision.
module pipe_scroller #(
  parameter int NUM_PIPES = 3,
  parameter int XW        = 11,
  parameter int SCREEN_W  = 640,
  parameter int PIPE_W    = 40,
  parameter int X_SPACING = 200,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 60,
  parameter int GAP_MAX   = 300,
  parameter int STEP_MAX  = 4,
  parameter int BIRD_X    = 160,
  parameter int SW        = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    start,
  input  logic                    freeze,
  input  logic [2:0]              speed,
  output logic [NUM_PIPES*XW-1:0] pipe_x,
  output logic [NUM_PIPES*10-1:0] pipe_gap_y,
  output logic [SW-1:0]           score,
  output logic                    score_pulse,
  output logic                    running,
  output logic                    halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [XW-1:0] WRAP_ADD = XW'(NUM_PIPES * X_SPACING);
  localparam logic [XW-1:0] BIRD_XV  = XW'(BIRD_X);
  localparam logic [9:0]    GAP_INIT = 10'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [SW-1:0] SCORE_MAX = {SW{1'b1}};

  state_t          state;
  logic [15:0]     lfsr;
  logic [XW-1:0]   px     [NUM_PIPES];
  logic [9:0]      gy     [NUM_PIPES];
  logic [XW-1:0]   px_mv  [NUM_PIPES];
  logic [XW-1:0]   px_nxt [NUM_PIPES];
  logic [9:0]      gy_nxt [NUM_PIPES];
  logic [XW-1:0]   step;
  logic            any_cross;

  function automatic logic [XW-1:0] clamp_step(input logic [2:0] s);
    if (s == 3'd0) return XW'(1);
    if (int'(s) > STEP_MAX) return XW'(STEP_MAX);
    return XW'(s);
  endfunction

  function automatic logic [9:0] new_gap(input logic [15:0] l);
    logic [10:0] g;
    g = 11'(GAP_MIN) + {3'b000, l[7:0]};
    return (g > 11'(GAP_MAX)) ? 10'(GAP_MAX) : g[9:0];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SCORE_MAX) ? v : v + SW'(1);
  endfunction

  function automatic logic [XW-1:0] init_x(input int i);
    return XW'(SCREEN_W + PIPE_W + i * X_SPACING);
  endfunction

  // Candidate positions for a RUN move; only one pipe can wrap or cross per edge
  always_comb begin
    step      = clamp_step(speed);
    any_cross = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      px_mv[i] = px[i] - step;
      if (px[i] <= step) begin
        px_nxt[i] = px_mv[i] + WRAP_ADD;
        gy_nxt[i] = new_gap(lfsr);
      end else begin
        px_nxt[i] = px_mv[i];
        gy_nxt[i] = gy[i];
        if (px[i] > BIRD_XV && px_mv[i] <= BIRD_XV) any_cross = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      running     <= 1'b0;
      halted      <= 1'b0;
      score       <= '0;
      score_pulse <= 1'b0;
      lfsr        <= LFSR_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= init_x(i);
        gy[i] <= GAP_INIT;
      end
    end else begin
      lfsr        <= lfsr_next(lfsr);
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (freeze) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              px[i] <= px_nxt[i];
              gy[i] <= gy_nxt[i];
            end
            if (any_cross) begin
              score       <= sat_inc(score);
              score_pulse <= 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state  <= IDLE;
            halted <= 1'b0;
            score  <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
              px[i] <= init_x(i);
              gy[i] <= GAP_INIT;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pipe_x     = '0;
    pipe_gap_y = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[i*XW +: XW]     = px[i];
      pipe_gap_y[i*10 +: 10] = gy[i];
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against a behavioural playfield model.
module tb_pipe_scroller;
  localparam int N  = 3;
  localparam int XW = 11;

  logic          Reset = 1'b1;
  logic          frame_clk = 1'b0;
  logic          start = 1'b0;
  logic          freeze = 1'b0;
  logic [2:0]    speed = 3'd1;
  logic [N*XW-1:0] pipe_x;
  logic [N*10-1:0] pipe_gap_y;
  logic [9:0]    score;
  logic          score_pulse;
  logic          running;
  logic          halted;

  pipe_scroller dut (
    .Reset(Reset), .frame_clk(frame_clk), .start(start), .freeze(freeze),
    .speed(speed), .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .score(score),
    .score_pulse(score_pulse), .running(running), .halted(halted)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  // Model of the playfield: 0 idle, 1 run, 2 halt
  int          m_px [N];
  int          m_gy [N];
  int          m_sc, m_pulse, m_st;
  logic [15:0] m_lf;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int dpx(input int i);
    return int'(pipe_x[i*XW +: XW]);
  endfunction

  function automatic int dgy(input int i);
    return int'(pipe_gap_y[i*10 +: 10]);
  endfunction

  task automatic model_positions();
    for (int i = 0; i < N; i++) begin
      m_px[i] = 680 + 200 * i;
      m_gy[i] = 180;
    end
    m_sc = 0;
  endtask

  task automatic model_reset();
    model_positions();
    m_st    = 0;
    m_pulse = 0;
    m_lf    = 16'hACE1;
  endtask

  task automatic model_edge();
    int st;
    bit cr;
    logic [15:0] lf0;
    if (Reset) begin
      model_reset();
      return;
    end
    lf0     = m_lf;
    m_lf    = {1'b0, m_lf[15:1]} ^ (m_lf[0] ? 16'hB400 : 16'h0000);
    m_pulse = 0;
    st = (speed == 3'd0) ? 1 : ((int'(speed) > 4) ? 4 : int'(speed));
    if (m_st == 0) begin
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      if (freeze) m_st = 2;
      else begin
        cr = 0;
        for (int i = 0; i < N; i++) begin
          if (m_px[i] <= st) begin
            m_px[i] = m_px[i] - st + 600;
            m_gy[i] = (60 + int'(lf0[7:0]) > 300) ? 300 : 60 + int'(lf0[7:0]);
          end else begin
            if (m_px[i] > 160 && m_px[i] - st <= 160) cr = 1;
            m_px[i] = m_px[i] - st;
          end
        end
        if (cr) begin
          m_pulse = 1;
          if (m_sc < 1023) m_sc++;
        end
      end
    end else begin
      if (start) begin
        model_positions();
        m_st = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pipe_x[%0d]", i), dpx(i), m_px[i]);
      chk($sformatf("gap_y[%0d]", i), dgy(i), m_gy[i]);
    end
    chk("score", int'(score), m_sc);
    chk("score_pulse", int'(score_pulse), m_pulse);
    chk("running", int'(running), int'(m_st == 1));
    chk("halted", int'(halted), int'(m_st == 2));
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_edge();
    @(negedge frame_clk);
    compare_all();
  endtask

  initial begin
    int n;
    int save0, save1;
    model_reset();
    @(negedge frame_clk);
    compare_all();
    chk("rst_px0", dpx(0), 680);
    chk("rst_px2", dpx(2), 1080);
    chk("rst_gy0", dgy(0), 180);
    chk("rst_lfsr", int'(dut.lfsr), 16'hACE1);
    Reset = 1'b0;

    freeze = 1'b1; tick(); chk("idle_ignores_freeze", int'(halted), 0);
    freeze = 1'b0;
    start = 1'b1; tick();
    chk("start_running", int'(running), 1);
    chk("start_no_move", dpx(0), 680);
    start = 1'b0; speed = 3'd1; tick();
    chk("move1_px0", dpx(0), 679);
    chk("move1_px1", dpx(1), 879);
    chk("move1_px2", dpx(2), 1079);
    speed = 3'd0; tick(); chk("speed0_px0", dpx(0), 678);
    speed = 3'd7; tick(); chk("speed7_px0", dpx(0), 674);
    speed = 3'd3; tick(); chk("speed3_px0", dpx(0), 671);

    speed = 3'd1;
    repeat (510) tick();
    chk("pre_cross_px0", dpx(0), 161);
    chk("pre_cross_pulse", int'(score_pulse), 0);
    tick();
    chk("cross_px0", dpx(0), 160);
    chk("cross_pulse", int'(score_pulse), 1);
    chk("cross_score", int'(score), 1);
    speed = 3'd2; tick();
    chk("post_cross_pulse", int'(score_pulse), 0);
    chk("post_cross_score", int'(score), 1);
    repeat (78) tick();
    chk("prewrap_px0", dpx(0), 2);
    tick();
    chk("wrap_px0", dpx(0), 600);
    chk("wrap_pulse", int'(score_pulse), 0);

    repeat (300) begin
      speed = 3'($urandom_range(0, 7));
      tick();
    end

    speed = 3'd4;
    n = 0;
    while (m_sc < 1023 && n < 60000) begin tick(); n++; end
    chk("sat_reach_score", int'(score), 1023);
    n = 0;
    do begin tick(); n++; end while (m_pulse == 0 && n < 300);
    chk("sat_pulse", int'(score_pulse), 1);
    chk("sat_score_hold", int'(score), 1023);

    save0 = m_px[0];
    save1 = m_px[1];
    freeze = 1'b1; tick();
    chk("freeze_halted", int'(halted), 1);
    chk("freeze_running", int'(running), 0);
    chk("freeze_px0", dpx(0), save0);
    repeat (50) begin
      freeze = 1'($urandom_range(0, 1));
      speed  = 3'($urandom_range(0, 7));
      tick();
    end
    chk("frozen_px0", dpx(0), save0);
    chk("frozen_px1", dpx(1), save1);
    freeze = 1'b0; start = 1'b1; tick();
    chk("restart_px0", dpx(0), 680);
    chk("restart_score", int'(score), 0);
    chk("restart_idle", int'(halted) + int'(running), 0);
    tick();
    chk("restart_run", int'(running), 1);
    start = 1'b0;

    repeat (400) begin
      speed  = 3'($urandom_range(0, 7));
      freeze = ($urandom_range(0, 63) == 0);
      start  = ($urandom_range(0, 15) == 0);
      tick();
    end
    freeze = 1'b0; start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    chk("back_in_run", int'(running), 1);
    speed = 3'd3;
    repeat (20) tick();

    @(posedge frame_clk);
    model_edge();
    #3 Reset = 1'b1;
    #1;
    chk("arst_px0", dpx(0), 680);
    chk("arst_px1", dpx(1), 880);
    chk("arst_gy0", dgy(0), 180);
    chk("arst_score", int'(score), 0);
    chk("arst_pulse", int'(score_pulse), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_halted", int'(halted), 0);
    chk("arst_lfsr", int'(dut.lfsr), 16'hACE1);
    model_reset();
    @(negedge frame_clk);
    compare_all();
    Reset = 1'b0;
    tick();
    chk("arst_first_edge_idle", int'(running), 0);
    start = 1'b1; tick(); start = 1'b0;
    speed = 3'd4;
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
